// File: rtl/skintone_pipe_ctrl.sv
// skintone_pipe_ctrl: valid/ready flow control around the fixed-latency,
// non-stallable Cb/Cr skin-tone transform pipelines. Pixels are admitted
// only when an output FIFO slot is already reserved for them. A tag shift
// register runs alongside the transforms, and a small FSM sequences frames
// through start, run and drain.
module skintone_pipe_ctrl #(
  parameter int LATENCY    = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_Y,
  input  logic [7:0]  in_Cb,
  input  logic [7:0]  in_Cr,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic [7:0]  pipe_Y,
  output logic [7:0]  pipe_Cb,
  output logic [7:0]  pipe_Cr,
  input  logic [7:0]  pipe_cb_t,
  input  logic [7:0]  pipe_cr_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_Y,
  output logic [7:0]  out_Cb,
  output logic [7:0]  out_Cr,
  output logic        out_sof,
  output logic        out_eof,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] pixel_count,
  output logic [7:0]  drop_count,
  output logic        proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Wide enough to hold inflight + fifo occupancy without overflow.
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e state_q, state_d;

  // Tag shift register, aligned with the transform pipeline depth.
  logic [LATENCY-1:0] tvld_q, tsof_q, teof_q;
  logic [7:0]         ty_q [LATENCY];

  // Output FIFO storage and control.
  logic [7:0]            fy_q  [FIFO_DEPTH];
  logic [7:0]            fcb_q [FIFO_DEPTH];
  logic [7:0]            fcr_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fsof_q, feof_q;
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         fcnt_q;

  logic [15:0] pix_cnt_q;
  logic [7:0]  drop_cnt_q;
  logic        proto_err_q, frame_done_q;

  logic          accept, tag_vld, fifo_wr, fifo_rd, drain_done;
  logic [CW-1:0] inflight;

  function automatic logic [CW-1:0] popcount(input logic [LATENCY-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < LATENCY; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  assign inflight = popcount(tvld_q);
  assign accept   = in_valid & in_ready;
  // Pixels accepted in IDLE without sof are consumed but never tagged.
  assign tag_vld  = accept & ((state_q != IDLE) | in_sof);
  assign fifo_wr  = tvld_q[LATENCY-1];
  assign out_valid = (fcnt_q != '0);
  assign fifo_rd  = out_valid & out_ready;
  // Drain completes on the edge that empties the FIFO, so frame_done appears
  // in the cycle right after the eof pixel is read.
  assign drain_done = (inflight == '0) && (fcnt_q == (fifo_rd ? CW'(1) : CW'(0)));

  assign pipe_Y  = in_Y;
  assign pipe_Cb = in_Cb;
  assign pipe_Cr = in_Cr;

  assign out_Y   = out_valid ? fy_q[rptr_q]   : 8'd0;
  assign out_Cb  = out_valid ? fcb_q[rptr_q]  : 8'd0;
  assign out_Cr  = out_valid ? fcr_q[rptr_q]  : 8'd0;
  assign out_sof = out_valid ? fsof_q[rptr_q] : 1'b0;
  assign out_eof = out_valid ? feof_q[rptr_q] : 1'b0;

  assign frame_done  = frame_done_q;
  assign pixel_count = pix_cnt_q;
  assign drop_count  = drop_cnt_q;
  assign proto_err   = proto_err_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: one frame at a time, drain before the next sof.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && in_sof) state_d = in_eof ? DRAIN : RUN;
      RUN:     if (accept && in_eof) state_d = DRAIN;
      DRAIN:   if (drain_done)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: credit-based ready from registered state only.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    in_ready = (state_q != DRAIN) && ((inflight + fcnt_q) < CW'(FIFO_DEPTH));
    busy     = (state_q != IDLE);
  end

  // Tag valid bits advance every edge; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tvld_q <= '0;
    else        tvld_q <= {tvld_q[LATENCY-2:0], tag_vld};
  end

  // Tag payload advances every edge; meaningful only where the valid bit is set.
  always_ff @(posedge clk) begin
    tsof_q   <= {tsof_q[LATENCY-2:0], in_sof};
    teof_q   <= {teof_q[LATENCY-2:0], in_eof};
    ty_q[0]  <= in_Y;
    for (int i = 1; i < LATENCY; i++) ty_q[i] <= ty_q[i-1];
  end

  // FIFO pointers and occupancy; simultaneous read and write at any level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (fifo_wr) wptr_q <= wptr_q + 1'b1;
      if (fifo_rd) rptr_q <= rptr_q + 1'b1;
      fcnt_q <= fcnt_q + CW'(fifo_wr) - CW'(fifo_rd);
    end
  end

  // FIFO storage: capture the transform results alongside the delayed tag.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fy_q[wptr_q]   <= ty_q[LATENCY-1];
      fcb_q[wptr_q]  <= pipe_cb_t;
      fcr_q[wptr_q]  <= pipe_cr_t;
      fsof_q[wptr_q] <= tsof_q[LATENCY-1];
      feof_q[wptr_q] <= teof_q[LATENCY-1];
    end
  end

  // Frame statistics and protocol error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        if (in_sof)                    pix_cnt_q  <= 16'd1;
        else if (drop_cnt_q != 8'hFF)  drop_cnt_q <= drop_cnt_q + 8'd1;
      end else if (state_q == RUN) begin
        pix_cnt_q <= pix_cnt_q + 16'd1;
        if (in_sof) proto_err_q <= 1'b1;
      end
    end
  end

  // One-cycle frame completion pulse on leaving DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done_q <= 1'b0;
    else        frame_done_q <= (state_q == DRAIN) && drain_done;
  end

endmodule
